// File: rtl/decode_pipe.sv
// -----------------------------------------------------------------------------
// decode_pipe
//   Decode stage back end. It holds the architectural register file, with
//   write-through bypass from the write-back port. It sign-extends the raw
//   immediate and captures the decoded instruction into the ID/EX pipeline
//   register. It also detects load-use hazards against the instruction
//   already held in ID/EX.
//
//   A detected hazard inserts a single bubble into ID/EX and asks fetch to
//   hold for one cycle. bubble_cnt_o is a saturating count of those bubbles.
//
// Parameters
//   DATA_W  datapath / register width
//   NREG    number of architectural registers (RA_W = clog2(NREG))
//   IMM_W   raw immediate width (2 <= IMM_W <= DATA_W)
//   CTRL_W  width of the side-effect control bundle
//   CNT_W   width of the hazard-bubble counter
//
// Ports
//   clk_i, rst_n_i              clock, asynchronous active-low reset
//   stall_i                     downstream hold, freezes ID/EX and counter
//   flush_i                     squash the instruction in decode
//   valid_i                     decode slot holds an instruction
//   rs1_i, rs2_i, rd_i          register specifiers
//   uses_rs1_i, uses_rs2_i      operand is actually read
//   is_load_i                   instruction is a load
//   pc_i, imm_i, ctrl_i         decode payload
//   wb_en_i, wb_dst_i, wb_data_i  register-file write port
//   valid_o ... is_load_o       ID/EX register contents
//   hazard_stall_o              combinational load-use stall request to fetch
//   bubble_cnt_o                saturating hazard-bubble count
// -----------------------------------------------------------------------------
module decode_pipe #(
  parameter  int DATA_W = 32,
  parameter  int NREG   = 32,
  parameter  int IMM_W  = 15,
  parameter  int CTRL_W = 12,
  parameter  int CNT_W  = 16,
  localparam int RA_W   = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,

  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,

  input  logic [RA_W-1:0]   rs1_i,
  input  logic [RA_W-1:0]   rs2_i,
  input  logic [RA_W-1:0]   rd_i,
  input  logic              uses_rs1_i,
  input  logic              uses_rs2_i,
  input  logic              is_load_i,

  input  logic [DATA_W-1:0] pc_i,
  input  logic [IMM_W-1:0]  imm_i,
  input  logic [CTRL_W-1:0] ctrl_i,

  input  logic              wb_en_i,
  input  logic [RA_W-1:0]   wb_dst_i,
  input  logic [DATA_W-1:0] wb_data_i,

  output logic              valid_o,
  output logic [DATA_W-1:0] pc_o,
  output logic [RA_W-1:0]   rd_o,
  output logic [RA_W-1:0]   rs1_o,
  output logic [RA_W-1:0]   rs2_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              is_load_o,

  output logic              hazard_stall_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] rf_q [NREG];
  logic              wb_ok;

  // The NREG bound only matters when NREG is not a power of two.
  assign wb_ok = wb_en_i && (wb_dst_i != '0) && (32'(wb_dst_i) < NREG);

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_ok) begin
      rf_q[wb_dst_i] <= wb_data_i;
    end
  end

  // Combinational reads. A same-cycle write to the read address wins, so
  // decode never sees a stale value one cycle behind write-back.
  logic [DATA_W-1:0] rdata1_d;
  logic [DATA_W-1:0] rdata2_d;

  always_comb begin
    rdata1_d = '0;
    if (rs1_i != '0) begin
      if (wb_en_i && (wb_dst_i == rs1_i)) begin
        rdata1_d = wb_data_i;
      end else if (32'(rs1_i) < NREG) begin
        rdata1_d = rf_q[rs1_i];
      end
    end
  end

  always_comb begin
    rdata2_d = '0;
    if (rs2_i != '0) begin
      if (wb_en_i && (wb_dst_i == rs2_i)) begin
        rdata2_d = wb_data_i;
      end else if (32'(rs2_i) < NREG) begin
        rdata2_d = rf_q[rs2_i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Immediate sign extension
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] imm_d;

  assign imm_d = DATA_W'($signed(imm_i));

  // ---------------------------------------------------------------------------
  // ID/EX pipeline register
  // ---------------------------------------------------------------------------
  logic              valid_q;
  logic [DATA_W-1:0] pc_q;
  logic [RA_W-1:0]   rd_q;
  logic [RA_W-1:0]   rs1_q;
  logic [RA_W-1:0]   rs2_q;
  logic [DATA_W-1:0] rdata1_q;
  logic [DATA_W-1:0] rdata2_q;
  logic [DATA_W-1:0] imm_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic              is_load_q;
  logic [CNT_W-1:0]  bubble_cnt_q;

  // Load-use hazard: the load in ID/EX has not produced its data yet, and the
  // decode instruction needs it. A load to register 0 never creates a
  // dependency.
  logic hazard;
  logic src_match;

  assign src_match = (uses_rs1_i && (rs1_i == rd_q)) ||
                     (uses_rs2_i && (rs2_i == rd_q));
  assign hazard    = valid_q && is_load_q && (rd_q != '0) && valid_i && src_match;

  // A stalled or flushed decode slot will not advance, so fetch need not hold.
  assign hazard_stall_o = hazard && !flush_i && !stall_i;

  // A bubble comes from a flush or from a hazard. In both cases the payload
  // still loads, but valid_o, ctrl_o and is_load_o are forced low. That keeps
  // any side effect from leaking out of a squashed slot.
  logic              bubble;
  logic              valid_d;
  logic [CTRL_W-1:0] ctrl_d;
  logic              is_load_d;
  logic [CNT_W-1:0]  bubble_cnt_d;

  always_comb begin
    bubble       = flush_i || hazard;
    valid_d      = 1'b0;
    ctrl_d       = '0;
    is_load_d    = 1'b0;
    bubble_cnt_d = bubble_cnt_q;

    if (!bubble) begin
      valid_d   = valid_i;
      ctrl_d    = valid_i ? ctrl_i : '0;
      is_load_d = valid_i && is_load_i;
    end

    // Only hazard bubbles are counted. Squashes are not hazard bubbles.
    if (!flush_i && hazard && (bubble_cnt_q != CNT_MAX)) begin
      bubble_cnt_d = bubble_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      rd_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rdata1_q     <= '0;
      rdata2_q     <= '0;
      imm_q        <= '0;
      ctrl_q       <= '0;
      is_load_q    <= 1'b0;
      bubble_cnt_q <= '0;
    end else if (!stall_i) begin
      valid_q      <= valid_d;
      pc_q         <= pc_i;
      rd_q         <= rd_i;
      rs1_q        <= rs1_i;
      rs2_q        <= rs2_i;
      rdata1_q     <= rdata1_d;
      rdata2_q     <= rdata2_d;
      imm_q        <= imm_d;
      ctrl_q       <= ctrl_d;
      is_load_q    <= is_load_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign valid_o      = valid_q;
  assign pc_o         = pc_q;
  assign rd_o         = rd_q;
  assign rs1_o        = rs1_q;
  assign rs2_o        = rs2_q;
  assign rdata1_o     = rdata1_q;
  assign rdata2_o     = rdata2_q;
  assign imm_o        = imm_q;
  assign ctrl_o       = ctrl_q;
  assign is_load_o    = is_load_q;
  assign bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_decode_pipe.sv
module tb_decode_pipe;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int IW = 15;
  localparam int CW = 12;
  localparam int BW = 2;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stall_i, flush_i, valid_i;
  logic [AW-1:0] rs1_i, rs2_i, rd_i;
  logic          uses_rs1_i, uses_rs2_i, is_load_i;
  logic [DW-1:0] pc_i;
  logic [IW-1:0] imm_i;
  logic [CW-1:0] ctrl_i;
  logic          wb_en_i;
  logic [AW-1:0] wb_dst_i;
  logic [DW-1:0] wb_data_i;

  logic          valid_o;
  logic [DW-1:0] pc_o;
  logic [AW-1:0] rd_o, rs1_o, rs2_o;
  logic [DW-1:0] rdata1_o, rdata2_o, imm_o;
  logic [CW-1:0] ctrl_o;
  logic          is_load_o;
  logic          hazard_stall_o;
  logic [BW-1:0] bubble_cnt_o;

  decode_pipe #(
    .DATA_W(DW), .NREG(NR), .IMM_W(IW), .CTRL_W(CW), .CNT_W(BW)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
    .uses_rs1_i(uses_rs1_i), .uses_rs2_i(uses_rs2_i), .is_load_i(is_load_i),
    .pc_i(pc_i), .imm_i(imm_i), .ctrl_i(ctrl_i),
    .wb_en_i(wb_en_i), .wb_dst_i(wb_dst_i), .wb_data_i(wb_data_i),
    .valid_o(valid_o), .pc_o(pc_o), .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
    .rdata1_o(rdata1_o), .rdata2_o(rdata2_o), .imm_o(imm_o), .ctrl_o(ctrl_o),
    .is_load_o(is_load_o), .hazard_stall_o(hazard_stall_o),
    .bubble_cnt_o(bubble_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          stall, flush, valid, u1, u2, ld, wb_en;
    logic [AW-1:0] rs1, rs2, rd, wb_dst;
    logic [DW-1:0] pc, wb_data;
    logic [IW-1:0] imm;
    logic [CW-1:0] ctrl;
  } in_t;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] pc;
    logic [AW-1:0] rd, rs1, rs2;
    logic [DW-1:0] rd1, rd2, imm;
    logic [CW-1:0] ctrl;
    logic          is_load;
    logic [BW-1:0] cnt;
  } st_t;

  st_t           exp_q[$];
  logic          hz_q[$];
  int            checks = 0;
  int            failures = 0;
  st_t           ms;
  logic [DW-1:0] mregs [NR];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_valid"}, 32'(valid_o), 0);
    chk({tag, "_pc"}, pc_o, 0);
    chk({tag, "_rd"}, 32'(rd_o), 0);
    chk({tag, "_rs1"}, 32'(rs1_o), 0);
    chk({tag, "_rs2"}, 32'(rs2_o), 0);
    chk({tag, "_rdata1"}, rdata1_o, 0);
    chk({tag, "_rdata2"}, rdata2_o, 0);
    chk({tag, "_imm"}, imm_o, 0);
    chk({tag, "_ctrl"}, 32'(ctrl_o), 0);
    chk({tag, "_is_load"}, 32'(is_load_o), 0);
    chk({tag, "_bubble_cnt"}, 32'(bubble_cnt_o), 0);
  endtask

  function automatic in_t nop();
    in_t t;
    t = '0;
    return t;
  endfunction

  // Register read as decode sees it: reg 0 is zero, a same-cycle write wins.
  function automatic logic [DW-1:0] mread(input logic [AW-1:0] a, input in_t t);
    if (a == 0) return '0;
    if (t.wb_en && t.wb_dst == a) return t.wb_data;
    return mregs[a];
  endfunction

  task automatic apply_inputs(input in_t t);
    stall_i = t.stall;  flush_i = t.flush;  valid_i = t.valid;
    rs1_i = t.rs1;  rs2_i = t.rs2;  rd_i = t.rd;
    uses_rs1_i = t.u1;  uses_rs2_i = t.u2;  is_load_i = t.ld;
    pc_i = t.pc;  imm_i = t.imm;  ctrl_i = t.ctrl;
    wb_en_i = t.wb_en;  wb_dst_i = t.wb_dst;  wb_data_i = t.wb_data;
  endtask

  // Reference behaviour of one clock cycle, written from the pipeline rules.
  task automatic apply_and_model(input in_t t);
    logic hazard;
    logic hz;
    st_t  n;
    apply_inputs(t);
    hazard = ms.valid && ms.is_load && (ms.rd != 0) && t.valid &&
             ((t.u1 && t.rs1 == ms.rd) || (t.u2 && t.rs2 == ms.rd));
    hz = hazard && !t.flush && !t.stall;
    n  = ms;
    if (!t.stall) begin
      n.pc  = t.pc;
      n.rd  = t.rd;
      n.rs1 = t.rs1;
      n.rs2 = t.rs2;
      n.rd1 = mread(t.rs1, t);
      n.rd2 = mread(t.rs2, t);
      n.imm = t.imm[IW-1] ? (32'(t.imm) - 32'h8000) : 32'(t.imm);
      if (t.flush || hazard) begin
        n.valid   = 1'b0;
        n.ctrl    = '0;
        n.is_load = 1'b0;
        if (!t.flush && ms.cnt < 3) n.cnt = ms.cnt + 2'd1;
      end else begin
        n.valid   = t.valid;
        n.ctrl    = t.valid ? t.ctrl : '0;
        n.is_load = t.valid && t.ld;
      end
    end
    hz_q.push_back(hz);
    exp_q.push_back(n);
    ms = n;
    if (t.wb_en && t.wb_dst != 0) mregs[t.wb_dst] = t.wb_data;
  endtask

  task automatic drive(input in_t t);
    @(negedge clk);
    apply_and_model(t);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic model_reset();
    ms = '0;
    for (int i = 0; i < NR; i++) mregs[i] = '0;
  endtask

  // Monitor: hazard request is checked mid low-phase, ID/EX just after the edge.
  initial begin
    st_t  e;
    logic h;
    forever begin
      @(negedge clk);
      #2;
      if (hz_q.size() > 0) begin
        h = hz_q.pop_front();
        chk("sb_hazard_stall", 32'(hazard_stall_o), 32'(h));
      end
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_valid", 32'(valid_o), 32'(e.valid));
        chk("sb_pc", pc_o, e.pc);
        chk("sb_rd", 32'(rd_o), 32'(e.rd));
        chk("sb_rs1", 32'(rs1_o), 32'(e.rs1));
        chk("sb_rs2", 32'(rs2_o), 32'(e.rs2));
        chk("sb_rdata1", rdata1_o, e.rd1);
        chk("sb_rdata2", rdata2_o, e.rd2);
        chk("sb_imm", imm_o, e.imm);
        chk("sb_ctrl", 32'(ctrl_o), 32'(e.ctrl));
        chk("sb_is_load", 32'(is_load_o), 32'(e.is_load));
        chk("sb_bubble_cnt", 32'(bubble_cnt_o), 32'(e.cnt));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t t, ld, use_t;
    int  exp_cnt [4] = '{1, 2, 3, 3};

    model_reset();
    apply_inputs(nop());
    #12;
    check_zero_outputs("reset");
    chk("reset_hazard_stall", 32'(hazard_stall_o), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Write-through bypass and register 0 behaviour.
    t = nop();
    t.valid = 1; t.u1 = 1; t.rs1 = 5; t.wb_en = 1; t.wb_dst = 5; t.wb_data = 32'hDEADBEEF;
    drive(t); after_edge();
    chk("bypass_rdata1", rdata1_o, 32'hDEADBEEF);
    t = nop();
    t.valid = 1; t.u1 = 1; t.rs1 = 0; t.wb_en = 1; t.wb_dst = 0; t.wb_data = 32'h12345678;
    drive(t); after_edge();
    chk("reg0_bypass", rdata1_o, 0);
    t.wb_en = 0;
    drive(t); after_edge();
    chk("reg0_read", rdata1_o, 0);
    t.rs1 = 5;
    drive(t); after_edge();
    chk("rf_read_5", rdata1_o, 32'hDEADBEEF);

    // Immediate sign extension.
    t = nop(); t.valid = 1; t.imm = 15'h4000;
    drive(t); after_edge();
    chk("imm_neg", imm_o, 32'hFFFFC000);
    t.imm = 15'h3FFF;
    drive(t); after_edge();
    chk("imm_pos", imm_o, 32'h00003FFF);

    // Counter saturation with a 2-bit counter: four load-use bubbles.
    for (int i = 0; i < 4; i++) begin
      ld = nop(); ld.valid = 1; ld.ld = 1; ld.rd = 3; ld.ctrl = 12'h010;
      drive(ld);
      use_t = nop(); use_t.valid = 1; use_t.u1 = 1; use_t.rs1 = 3; use_t.ctrl = 12'h020;
      drive(use_t); after_edge();
      chk("sat_bubble_cnt", 32'(bubble_cnt_o), 32'(exp_cnt[i]));
    end

    // Reset in the middle of a hazard, with valid_o high.
    ld = nop(); ld.valid = 1; ld.ld = 1; ld.rd = 7; ld.ctrl = 12'h001; ld.pc = 32'h40;
    drive(ld);
    @(negedge clk);
    use_t = nop(); use_t.valid = 1; use_t.u2 = 1; use_t.rs2 = 7; use_t.ctrl = 12'h0AB;
    apply_inputs(use_t);
    #1;
    chk("pre_reset_hazard", 32'(hazard_stall_o), 1);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    chk("midreset_hazard_stall", 32'(hazard_stall_o), 0);
    model_reset();
    @(posedge clk);
    #1;
    check_zero_outputs("held_reset");
    @(negedge clk);
    rst_n = 1'b1;
    t = nop(); t.valid = 1; t.u1 = 1; t.rs1 = 5; t.ctrl = 12'h055; t.pc = 32'h80;
    apply_and_model(t);
    after_edge();
    chk("post_reset_rf", rdata1_o, 0);
    chk("post_reset_valid", 32'(valid_o), 1);

    // Load-use with a single-cycle penalty.
    drive(ld); after_edge();
    drive(use_t);
    #1;
    chk("loaduse_hazard", 32'(hazard_stall_o), 1);
    after_edge();
    chk("loaduse_valid", 32'(valid_o), 0);
    chk("loaduse_ctrl", 32'(ctrl_o), 0);
    chk("loaduse_cnt", 32'(bubble_cnt_o), 1);
    drive(use_t);
    #1;
    chk("loaduse_clear", 32'(hazard_stall_o), 0);
    ld.rd = 0;
    drive(ld);
    use_t.rs2 = 0;
    drive(use_t);
    #1;
    chk("rd0_no_hazard", 32'(hazard_stall_o), 0);
    after_edge();
    chk("rd0_valid", 32'(valid_o), 1);

    // Priority: stall over flush over hazard.
    ld.rd = 7;
    drive(ld);
    t = use_t; t.rs2 = 7; t.stall = 1; t.flush = 1; t.pc = 32'h100;
    drive(t);
    #1;
    chk("stall_hazard_masked", 32'(hazard_stall_o), 0);
    after_edge();
    chk("stall_hold_valid", 32'(valid_o), 1);
    chk("stall_hold_pc", pc_o, 32'h40);
    chk("stall_hold_rd", 32'(rd_o), 7);
    t.stall = 0; t.ctrl = 12'hFFF; t.pc = 32'h2000;
    drive(t); after_edge();
    chk("flush_valid", 32'(valid_o), 0);
    chk("flush_ctrl", 32'(ctrl_o), 0);
    chk("flush_pc", pc_o, 32'h2000);
    chk("flush_cnt", 32'(bubble_cnt_o), 1);

    // Randomised traffic, biased toward register collisions.
    for (int i = 0; i < 400; i++) begin
      t = nop();
      t.stall   = ($urandom_range(0, 99) < 15);
      t.flush   = ($urandom_range(0, 99) < 10);
      t.valid   = ($urandom_range(0, 99) < 85);
      t.u1      = 1'($urandom);
      t.u2      = 1'($urandom);
      t.ld      = 1'($urandom);
      t.rs1     = 5'($urandom_range(0, 7));
      t.rs2     = 5'($urandom_range(0, 7));
      t.rd      = 5'($urandom_range(0, 7));
      t.pc      = $urandom;
      t.imm     = 15'($urandom);
      t.ctrl    = 12'($urandom);
      t.wb_en   = 1'($urandom);
      t.wb_dst  = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      t.wb_data = $urandom;
      drive(t);
    end

    repeat (3) @(negedge clk);
    chk("queue_drain", 32'(exp_q.size() + hz_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
